// File: rtl/core_pkg.sv
// Shared fetch-path types: FSM states, architectural widths and buffer entry layout.
package core_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned INSTRUCTION_ALIGN = 4;

  typedef enum logic [0:0] {
    S_IDLE,
    S_WAIT
  } fetch_state;

  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
  } fetch_entry;

  // Instruction addresses must sit on a word boundary.
  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return (addr % INSTRUCTION_ALIGN) == '0;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Valid/ready stream port between fetch and decode.
interface skid_buffer_port #(
  parameter int unsigned WIDTH = 32
) ();

  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  // Producer side: drives valid/data, samples ready.
  modport downstream (
    output valid,
    output data,
    input  ready
  );

  // Consumer side: samples valid/data, drives ready.
  modport upstream (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// Small in-order FIFO of fetched words with flush; head is always slot 0.
module fetch_skid_buffer
  import core_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic          push_i,
  input  fetch_entry    entry_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output fetch_entry    head_o
);

  fetch_entry    entry_q [DEPTH];
  fetch_entry    entry_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] wr_idx;
  logic          pop_eff;
  logic          push_eff;

  // Next-state: shift on pop, write behind the surviving entries on push.
  always_comb begin
    entry_d  = entry_q;
    count_d  = count_q;
    pop_eff  = pop_i && (count_q != '0);
    push_eff = push_i && ((count_q < CW'(DEPTH)) || pop_eff);
    wr_idx   = count_q - CW'(pop_eff);
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (pop_eff) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          entry_d[i] = entry_q[i+1];
        end
      end
      if (push_eff) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (wr_idx == CW'(i)) begin
            entry_d[i] = entry_i;
          end
        end
      end
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = entry_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding memory reads, buffers
// returned words for the decoder and handles execute redirects.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned     BUFFER_DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   nreset,
  skid_buffer_port.downstream    decoder,
  output logic [XLEN-1:0]        fetched_pc,
  output logic                   mem_read_request,
  output logic [XLEN-1:0]        mem_read_addr,
  input  logic                   mem_read_ack,
  input  logic [XLEN-1:0]        mem_read_data,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_target,
  output logic                   fetch_error
);

  localparam int unsigned CW = $clog2(BUFFER_DEPTH + 1);

  fetch_state      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic            drop_q, drop_d;
  logic            err_q, err_d;

  logic            push;
  logic            pop;
  logic            flush;
  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   count_next;
  fetch_entry      head;
  fetch_entry      push_entry;

  assign pop        = (buf_count != '0) && decoder.ready;
  assign push_entry = '{word: mem_read_data, pc: addr_q};

  fetch_skid_buffer #(
    .DEPTH (BUFFER_DEPTH)
  ) u_buffer (
    .clock   (clock),
    .nreset  (nreset),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (flush),
    .count_o (buf_count),
    .head_o  (head)
  );

  // Next-state: redirect wins; otherwise issue when room remains, retire on ack.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    drop_d     = drop_q;
    err_d      = err_q;
    push       = 1'b0;
    flush      = 1'b0;
    count_next = buf_count - CW'(pop);

    if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = redirect_target;
      if (!is_aligned(redirect_target)) begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (!redirect_valid && !err_q && (count_next <= CW'(BUFFER_DEPTH - 1))) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_read_ack) begin
          req_d   = 1'b0;
          drop_d  = 1'b0;
          state_d = S_IDLE;
          if (!redirect_valid && !drop_q) begin
            push = 1'b1;
            pc_d = addr_q + XLEN'(INSTRUCTION_ALIGN);
          end
        end else if (redirect_valid) begin
          // The bus read cannot be withdrawn; let it finish and discard it.
          drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and address registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      req_q   <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  assign decoder.valid    = (buf_count != '0);
  assign decoder.data     = head.word;
  assign fetched_pc       = head.pc;
  assign mem_read_request = req_q;
  assign mem_read_addr    = addr_q;
  assign fetch_error      = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory responder.
module tb_fetch_unit;
  import core_pkg::*;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic [31:0] fetched_pc;
  logic        mem_read_request;
  logic [31:0] mem_read_addr;
  logic        mem_read_ack = 1'b0;
  logic [31:0] mem_read_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        fetch_error;

  skid_buffer_port #(.WIDTH(32)) dec_if ();

  fetch_unit #(
    .RESET_PC     (32'h0000_0100),
    .BUFFER_DEPTH (2)
  ) dut (
    .clock            (clock),
    .nreset           (nreset),
    .decoder          (dec_if),
    .fetched_pc       (fetched_pc),
    .mem_read_request (mem_read_request),
    .mem_read_addr    (mem_read_addr),
    .mem_read_ack     (mem_read_ack),
    .mem_read_data    (mem_read_data),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .fetch_error      (fetch_error)
  );

  initial forever #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int          lat = 1;
  int          cnt = 0;
  bit          prev_req = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [31:0] req_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_word[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // One clock: log handshakes/requests, drive memory response, advance to next negedge.
  task automatic step();
    if (nreset) begin
      if (dec_if.valid && dec_if.ready && !redirect_valid) begin
        got_pc.push_back(fetched_pc);
        got_word.push_back(dec_if.data);
      end
      if (mem_read_request && !prev_req) begin
        req_log.push_back(mem_read_addr);
        hold_addr = mem_read_addr;
      end else if (mem_read_request) begin
        check("addr_hold", mem_read_addr, hold_addr);
      end
      prev_req = mem_read_request;
      if (mem_read_ack) begin
        mem_read_ack  = 1'b0;
        mem_read_data = 32'hBAD0_BAD0;
      end else if (mem_read_request) begin
        cnt++;
        if (cnt >= lat) begin
          mem_read_ack  = 1'b1;
          mem_read_data = memword(mem_read_addr);
          cnt           = 0;
        end
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    nreset         = 1'b0;
    mem_read_ack   = 1'b0;
    mem_read_data  = 32'hBAD0_BAD0;
    redirect_valid = 1'b0;
    dec_if.ready   = 1'b0;
    cnt            = 0;
    prev_req       = 1'b0;
    req_log.delete();
    got_pc.delete();
    got_word.delete();
    steps(2);
    nreset = 1'b1;
  endtask

  initial begin
    dec_if.ready = 1'b0;
    @(negedge clock);
    do_reset();
    check("rst_valid", 32'(dec_if.valid), 32'd0);
    check("rst_req", 32'(mem_read_request), 32'd0);
    check("rst_data", dec_if.data, 32'h0);
    check("rst_pc", fetched_pc, 32'h0);
    check("rst_err", 32'(fetch_error), 32'd0);

    // 1: streaming with ready high
    lat = 1;
    dec_if.ready = 1'b1;
    steps(12);
    check("t1_nreq", 32'(req_log.size() >= 3), 32'd1);
    check("t1_req0", req_log[0], 32'h0000_0100);
    check("t1_req1", req_log[1], 32'h0000_0104);
    check("t1_req2", req_log[2], 32'h0000_0108);
    check("t1_ngot", 32'(got_pc.size() >= 3), 32'd1);
    check("t1_w0", got_word[0], 32'hC0DE_0100);
    check("t1_w1", got_word[1], 32'hC0DE_0104);
    check("t1_w2", got_word[2], 32'hC0DE_0108);
    foreach (got_pc[i]) check("t1_order", got_pc[i], 32'h100 + 32'(4 * i));

    // 2: backpressure fills exactly two entries
    do_reset();
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 4) begin
        check("t2_hold_data", dec_if.data, 32'hC0DE_0100);
        check("t2_hold_pc", fetched_pc, 32'h0000_0100);
        check("t2_req_low", 32'(mem_read_request), 32'd0);
      end
    end
    check("t2_nreq", 32'(req_log.size()), 32'd2);
    check("t2_ngot", 32'(got_pc.size()), 32'd0);
    dec_if.ready = 1'b1;
    steps(8);
    check("t2_req2", req_log[2], 32'h0000_0108);
    check("t2_pc0", got_pc[0], 32'h0000_0100);
    check("t2_pc1", got_pc[1], 32'h0000_0104);
    check("t2_pc2", got_pc[2], 32'h0000_0108);
    check("t2_w1", got_word[1], 32'hC0DE_0104);

    // 3: redirect while waiting on a slow read
    do_reset();
    lat = 3;
    dec_if.ready = 1'b1;
    steps(2);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    check("t3_req_held", 32'(mem_read_request), 32'd1);
    check("t3_addr_held", mem_read_addr, 32'h0000_0100);
    steps(11);
    check("t3_req1", req_log[1], 32'h0000_0200);
    check("t3_pc0", got_pc[0], 32'h0000_0200);
    check("t3_w0", got_word[0], 32'hC0DE_0200);
    begin
      int n100 = 0;
      foreach (got_pc[i]) if (got_pc[i] == 32'h100) n100++;
      check("t3_dropped", 32'(n100), 32'd0);
    end

    // 4: redirect coincides with ack and decoder pop
    do_reset();
    lat = 1;
    steps(3);
    dec_if.ready    = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    check("t4_empty", 32'(dec_if.valid), 32'd0);
    check("t4_req_low", 32'(mem_read_request), 32'd0);
    steps(6);
    check("t4_req2", req_log[2], 32'h0000_0300);
    check("t4_pc0", got_pc[0], 32'h0000_0300);
    check("t4_w0", got_word[0], 32'hC0DE_0300);

    // 5a: misaligned redirect halts fetching
    do_reset();
    lat = 3;
    dec_if.ready = 1'b1;
    steps(2);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0202;
    step();
    redirect_valid = 1'b0;
    check("t5_err", 32'(fetch_error), 32'd1);
    check("t5_valid", 32'(dec_if.valid), 32'd0);
    check("t5_req_held", 32'(mem_read_request), 32'd1);
    steps(6);
    check("t5_nreq", 32'(req_log.size()), 32'd1);
    check("t5_err_sticky", 32'(fetch_error), 32'd1);
    check("t5_req_low", 32'(mem_read_request), 32'd0);
    check("t5_ngot", 32'(got_pc.size()), 32'd0);
    #2 nreset = 1'b0;
    #1 check("t5_err_clr", 32'(fetch_error), 32'd0);

    // 5b: asynchronous reset during an outstanding read
    do_reset();
    lat = 3;
    steps(6);
    check("t5b_pre_valid", 32'(dec_if.valid), 32'd1);
    check("t5b_pre_req", 32'(mem_read_request), 32'd1);
    check("t5b_pre_addr", mem_read_addr, 32'h0000_0104);
    #2 nreset = 1'b0;
    #1;
    check("t5b_valid", 32'(dec_if.valid), 32'd0);
    check("t5b_req", 32'(mem_read_request), 32'd0);
    check("t5b_data", dec_if.data, 32'h0);
    check("t5b_pc", fetched_pc, 32'h0);
    @(negedge clock);

    // 6: PC wraps from the top of the address space
    do_reset();
    lat = 1;
    dec_if.ready    = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    steps(6);
    check("t6_req0", req_log[0], 32'hFFFF_FFFC);
    check("t6_req1", req_log[1], 32'h0000_0000);
    check("t6_pc0", got_pc[0], 32'hFFFF_FFFC);
    check("t6_w0", got_word[0], 32'hC0DE_FFFC);
    check("t6_pc1", got_pc[1], 32'h0000_0000);
    check("t6_w1", got_word[1], 32'hC0DE_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
